fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter OP_JMP, default 4'h6, giving the unconditional-jump opcode resolved inside fetch.
REQ-003 The block SHALL have parameter OP_HALT, default 4'hF, giving the halt opcode.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: starts fetching from IDLE.
REQ-007 The block SHALL have port rom_addr, output, 8 bits: instruction address to ROM, equal to pc.
REQ-008 The block SHALL have port rom_data, input, 16 bits: combinational ROM instruction word, [15:12] opcode, [11:8] reserved, [7:0] imm.
REQ-009 The block SHALL have port ir, output, 16 bits: registered instruction for decode.
REQ-010 The block SHALL have port ir_pc, output, 8 bits: address ir was fetched from.
REQ-011 The block SHALL have port ir_valid, output, 1 bit: ir holds an instruction not yet accepted.
REQ-012 The block SHALL have port ir_ready, input, 1 bit: decode accepts ir this cycle.
REQ-013 The block SHALL have port redir_valid, input, 1 bit: execute-stage PC redirect request.
REQ-014 The block SHALL have port redir_pc, input, 8 bits: redirect target.
REQ-015 The block SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, HALT; IDLE->FETCH when en=1; FETCH->HALT on a fetched OP_HALT; HALT->FETCH only on redir_valid.
REQ-017 rom_addr SHALL equal pc combinationally in every state; ROM read latency is zero, so rom_data is sampled in the cycle it is addressed.
REQ-018 The block SHALL advance ("fetch slot") in FETCH only when ir_valid=0 or ir_ready=1.
REQ-019 In a fetch slot with a normal opcode: ir<=rom_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-020 In a fetch slot with opcode OP_JMP: pc<=rom_data[7:0]; the JMP is not forwarded; ir_valid<=0 if ir_ready=1, otherwise unchanged, giving one bubble.
REQ-021 In a fetch slot with opcode OP_HALT: state<=HALT, pc unchanged, HALT not forwarded; ir_valid clears once the pending ir is accepted.
REQ-022 When ir_valid=1 and ir_ready=0, ir, ir_pc, ir_valid and pc SHALL hold unchanged.
REQ-023 redir_valid SHALL have highest priority in any state except IDLE: pc<=redir_pc, ir_valid<=0 (flush, even if ir_ready=1), state<=FETCH; rom_data that cycle is discarded.
REQ-024 Opcode 4'h0 (NOP) and reserved bits SHALL be forwarded unmodified; fetch does not decode any opcode other than OP_JMP and OP_HALT.
REQ-025 In IDLE and HALT, ir_valid SHALL fall to 0 after any pending ir is accepted, and no new instruction is registered.
REQ-026 The block SHALL assert halted=1 exactly while state=HALT.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force: state=IDLE, pc=RESET_PC, ir=16'h0000, ir_pc=8'h00, ir_valid=0, halted=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state with no partial update on release.
REQ-029 The first fetch after reset release SHALL come from RESET_PC.

Structure
REQ-030 Opcode constants (NOP 4'h0, LOAD 4'h1, ADD 4'h2, JMP 4'h6, OUT 4'h8, HALT 4'hF), the FSM state encoding and the instruction field positions SHALL live in shared package cpu_pkg.
REQ-031 The PC SHALL be one sub-module, program_counter, providing load-target, increment and hold with async active-low reset; fetch_unit owns the FSM and the IR.

Verification
REQ-032 Reset, en=1, ir_ready=1, with the standard ROM program: the bench SHALL see ir/ir_pc = 1001/00, 8000/01, 2001/02, 8000/03, then one bubble (JMP at 04), then 8000/01, repeating.
REQ-033 Hold ir_ready=0 for 3 cycles while ir=2001: ir, ir_pc=02, pc=03 stable and rom_addr=03; on release, 8000/03 follows next cycle.
REQ-034 redir_valid=1, redir_pc=8'h03 while ir_valid=1 and ir_ready=0: the next cycle has ir_valid=0 and rom_addr=03, and the following cycle has ir=8000, ir_pc=03.
REQ-035 ROM word F000 at 8'h02: after 1001 and 8000, halted=1, ir_valid=0, pc stays 02; redir_pc=00 resumes with ir=1001.
REQ-036 Sequential code at 8'hFF: ir_pc=FF is followed by ir_pc=00 (wrap).
REQ-037 Assert rst_n=0 asynchronously mid-stall: outputs clear before the next clk edge, and the first fetch after release is from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction layout, fetch FSM encoding.
// Latency: n/a (package only, no logic).
// Backpressure: n/a.
//
// Instruction word layout (16 bits): [15:12] opcode, [11:8] reserved, [7:0] imm.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  // Field positions inside an instruction word
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RSVD_MSB = 11;
  localparam int RSVD_LSB = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  // Opcode map
  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LOAD = 4'h1;
  localparam logic [3:0] OPC_ADD  = 4'h2;
  localparam logic [3:0] OPC_JMP  = 4'h6;
  localparam logic [3:0] OPC_OUT  = 4'h8;
  localparam logic [3:0] OPC_HALT = 4'hF;

  // Packed view of an instruction word; field order matches the positions above
  typedef struct packed {
    logic [OPC_MSB-OPC_LSB:0]   opcode;
    logic [RSVD_MSB-RSVD_LSB:0] rsvd;
    logic [IMM_MSB-IMM_LSB:0]   imm;
  } instr_t;

  // Fetch FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Sequential successor of a PC; wraps 8'hFF -> 8'h00 by width truncation
  function automatic logic [PC_W-1:0] pc_plus1(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: load-target, increment or hold.
// Latency: 1 cycle from i_load/i_inc to o_pc; load wins over increment.
// Backpressure: none; the caller simply leaves both controls low to hold.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset (loads RESET_PC)
//   i_load      - load i_load_pc next edge
//   i_load_pc   - load target
//   i_inc       - advance by one (modulo 256) next edge
//   o_pc        - current PC
module program_counter
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_pc,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= pc_plus1(r_pc);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives ROM address from PC, registers the word into IR,
// resolves JMP and HALT locally, honours execute-stage redirects.
// Latency: ROM is read combinationally; a fetched word appears in ir the next cycle.
// Backpressure: ir_valid/ir_ready; while ir_valid && !ir_ready, ir, ir_pc and pc hold.
//
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   en                 - leave IDLE and start fetching
//   rom_addr/rom_data  - zero-latency ROM port (rom_addr == pc always)
//   ir, ir_pc          - registered instruction and the address it came from
//   ir_valid/ir_ready  - handshake toward decode
//   redir_valid/_pc    - PC redirect from execute (ignored in IDLE)
//   halted             - high while the FSM sits in HALT
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter logic [3:0]      OP_JMP   = 4'h6,
  parameter logic [3:0]      OP_HALT  = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redir_valid,
  input  logic [PC_W-1:0]    redir_pc,
  output logic               halted
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;

  instr_t          r_ir;
  logic [PC_W-1:0] r_ir_pc;
  logic            r_ir_valid;

  instr_t          w_instr;
  logic [PC_W-1:0] w_pc;
  logic            w_slot;
  logic            w_pc_load;
  logic [PC_W-1:0] w_pc_target;
  logic            w_pc_inc;
  logic            w_ir_load;
  logic            w_ir_valid_nxt;

  assign w_instr = instr_t'(rom_data);

  // A fetch slot exists only when the IR is free or being drained this cycle.
  assign w_slot = (r_state == ST_FETCH) && (!r_ir_valid || ir_ready);

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pc_load),
    .i_load_pc (w_pc_target),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_load      = 1'b0;
    w_pc_target    = redir_pc;
    w_pc_inc       = 1'b0;
    w_ir_load      = 1'b0;
    w_ir_valid_nxt = r_ir_valid;

    if (redir_valid && (r_state != ST_IDLE)) begin
      // Redirect beats everything: flush IR even if decode is taking it,
      // and discard this cycle's ROM word.
      w_state_nxt    = ST_FETCH;
      w_pc_load      = 1'b1;
      w_pc_target    = redir_pc;
      w_ir_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ir_ready) begin
            w_ir_valid_nxt = 1'b0;
          end
          if (en) begin
            w_state_nxt = ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (w_slot) begin
            if (w_instr.opcode == OP_JMP) begin
              // Resolved here and not forwarded, so decode sees one bubble.
              w_pc_load   = 1'b1;
              w_pc_target = w_instr.imm;
              if (ir_ready) begin
                w_ir_valid_nxt = 1'b0;
              end
            end else if (w_instr.opcode == OP_HALT) begin
              // PC parks on the HALT word; only a redirect moves it again.
              w_state_nxt = ST_HALT;
              if (ir_ready) begin
                w_ir_valid_nxt = 1'b0;
              end
            end else begin
              w_ir_load      = 1'b1;
              w_ir_valid_nxt = 1'b1;
              w_pc_inc       = 1'b1;
            end
          end
        end

        ST_HALT: begin
          if (ir_ready) begin
            w_ir_valid_nxt = 1'b0;
          end
        end

        default: begin
          w_state_nxt    = ST_IDLE;
          w_ir_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_ir_valid <= w_ir_valid_nxt;
      if (w_ir_load) begin
        r_ir    <= w_instr;
        r_ir_pc <= w_pc;
      end
    end
  end

  assign rom_addr = w_pc;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases push expected {ir, ir_pc} into a
// queue; a negedge monitor pops and compares on every ir_valid && ir_ready.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redir_valid;
  logic [7:0]  redir_pc;
  logic        halted;

  logic [15:0] rom [256];
  logic [23:0] exp_q [$];
  logic        mon_en;
  int          errors;
  int          checks;
  logic [9:0]  vpat;

  assign rom_data = rom[rom_addr];

  fetch_unit #(
    .RESET_PC (8'h00),
    .OP_JMP   (4'h6),
    .OP_HALT  (4'hF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: an accepted IR must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && ir_valid && ir_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ir=%h ir_pc=%h with nothing expected", ir, ir_pc);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({ir, ir_pc} !== e) begin
          errors++;
          $display("FAIL sb_ir: got ir=%h ir_pc=%h expected ir=%h ir_pc=%h",
                   ir, ir_pc, e[23:8], e[7:0]);
        end
      end
    end
  end

  task automatic push(input logic [15:0] i, input logic [7:0] a);
    exp_q.push_back({i, a});
  endtask

  // Standard program: LOAD 1, OUT, ADD 1, OUT, JMP 01
  task automatic load_std();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1001;
    rom[1] = 16'h8000;
    rom[2] = 16'h2001;
    rom[3] = 16'h8000;
    rom[4] = 16'h6001;
  endtask

  // Leaves the bench at posedge+1 with the DUT in IDLE and inputs quiet.
  task automatic do_reset();
    mon_en      = 1'b0;
    en          = 1'b0;
    ir_ready    = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    mon_en = 1'b0;
    en = 1'b0;
    ir_ready = 1'b0;
    redir_valid = 1'b0;
    redir_pc = 8'h00;
    rst_n = 1'b1;
    vpat = '0;

    // ---- A: reset values, then standard loop with JMP bubble ----
    load_std();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ir", 32'(ir), 32'h0000);
    chk("rst_ir_pc", 32'(ir_pc), 32'h00);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push(16'h1001, 8'h00);
    push(16'h8000, 8'h01);
    push(16'h2001, 8'h02);
    push(16'h8000, 8'h03);
    push(16'h8000, 8'h01);
    push(16'h2001, 8'h02);
    push(16'h8000, 8'h03);
    en = 1'b1;
    ir_ready = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      vpat[k] = ir_valid;
    end
    mon_en = 1'b0;
    ir_ready = 1'b0;
    chk("A_valid_pattern", 32'(vpat), 32'b0111011110);
    chk("A_drained", exp_q.size(), 0);

    // ---- B: stall three cycles on 2001/02 ----
    load_std();
    do_reset();
    push(16'h1001, 8'h00);
    push(16'h8000, 8'h01);
    push(16'h2001, 8'h02);
    push(16'h8000, 8'h03);
    en = 1'b1;
    ir_ready = 1'b1;
    mon_en = 1'b1;
    repeat (4) step();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("B_stall_ir", 32'(ir), 32'h2001);
      chk("B_stall_rom_addr", 32'(rom_addr), 32'h03);
      step();
    end
    chk("B_stall_ir_pc", 32'(ir_pc), 32'h02);
    chk("B_stall_ir_valid", 32'(ir_valid), 32'h1);
    ir_ready = 1'b1;
    step();
    chk("B_release_ir", 32'(ir), 32'h8000);
    chk("B_release_ir_pc", 32'(ir_pc), 32'h03);
    step();
    mon_en = 1'b0;
    ir_ready = 1'b0;
    chk("B_drained", exp_q.size(), 0);

    // ---- C: redirect while stalled flushes the IR ----
    load_std();
    do_reset();
    push(16'h1001, 8'h00);
    push(16'h8000, 8'h03);
    en = 1'b1;
    ir_ready = 1'b1;
    mon_en = 1'b1;
    repeat (3) step();
    chk("C_pre_ir_pc", 32'(ir_pc), 32'h01);
    ir_ready = 1'b0;
    redir_valid = 1'b1;
    redir_pc = 8'h03;
    step();
    redir_valid = 1'b0;
    chk("C_flush_valid", 32'(ir_valid), 32'h0);
    chk("C_flush_rom_addr", 32'(rom_addr), 32'h03);
    ir_ready = 1'b1;
    step();
    chk("C_after_ir", 32'(ir), 32'h8000);
    chk("C_after_ir_pc", 32'(ir_pc), 32'h03);
    step();
    mon_en = 1'b0;
    ir_ready = 1'b0;
    chk("C_drained", exp_q.size(), 0);

    // ---- D: HALT at 02, resume by redirect to 00 ----
    load_std();
    rom[2] = 16'hF000;
    do_reset();
    push(16'h1001, 8'h00);
    push(16'h8000, 8'h01);
    en = 1'b1;
    ir_ready = 1'b1;
    mon_en = 1'b1;
    repeat (4) step();
    chk("D_halted", 32'(halted), 32'h1);
    chk("D_halt_valid", 32'(ir_valid), 32'h0);
    chk("D_halt_pc", 32'(rom_addr), 32'h02);
    step();
    chk("D_halt_hold", 32'(halted), 32'h1);
    chk("D_halt_pc_hold", 32'(rom_addr), 32'h02);
    push(16'h1001, 8'h00);
    redir_valid = 1'b1;
    redir_pc = 8'h00;
    step();
    redir_valid = 1'b0;
    chk("D_resume_halted", 32'(halted), 32'h0);
    step();
    chk("D_resume_ir", 32'(ir), 32'h1001);
    step();
    mon_en = 1'b0;
    ir_ready = 1'b0;
    chk("D_drained", exp_q.size(), 0);

    // ---- E: redirect ignored in IDLE; wrap FF -> 00; NOP/reserved forwarded ----
    for (int i = 0; i < 256; i++) rom[i] = {8'h1A, 8'(i)};
    rom[8'hFF] = 16'h05FF;
    do_reset();
    redir_valid = 1'b1;
    redir_pc = 8'h55;
    step();
    chk("E_idle_redir_ignored", 32'(rom_addr), 32'h00);
    redir_valid = 1'b0;
    en = 1'b1;
    ir_ready = 1'b1;
    step();
    redir_valid = 1'b1;
    redir_pc = 8'hFE;
    push(16'h1AFE, 8'hFE);
    push(16'h05FF, 8'hFF);
    push(16'h1A00, 8'h00);
    push(16'h1A01, 8'h01);
    mon_en = 1'b1;
    step();
    redir_valid = 1'b0;
    chk("E_redir_addr", 32'(rom_addr), 32'hFE);
    repeat (3) step();
    chk("E_wrap_ir_pc", 32'(ir_pc), 32'h00);
    chk("E_wrap_rom_addr", 32'(rom_addr), 32'h01);
    repeat (2) step();
    mon_en = 1'b0;
    ir_ready = 1'b0;
    chk("E_drained", exp_q.size(), 0);

    // ---- F: async reset mid-stall, restart from RESET_PC ----
    load_std();
    do_reset();
    en = 1'b1;
    repeat (3) step();
    chk("F_stall_valid", 32'(ir_valid), 32'h1);
    chk("F_stall_rom_addr", 32'(rom_addr), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("F_async_ir", 32'(ir), 32'h0000);
    chk("F_async_valid", 32'(ir_valid), 32'h0);
    chk("F_async_rom_addr", 32'(rom_addr), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h1001, 8'h00);
    ir_ready = 1'b1;
    mon_en = 1'b1;
    repeat (2) step();
    chk("F_first_ir_pc", 32'(ir_pc), 32'h00);
    chk("F_first_ir", 32'(ir), 32'h1001);
    step();
    mon_en = 1'b0;
    ir_ready = 1'b0;
    chk("F_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
